// File: rtl/calc1_req_arbiter_if.sv
// calc1_req_arbiter_if: four requester cmd/data ports with their responses, plus the shared ALU issue/result bus; slave = arbiter side, master = environment side
interface calc1_req_arbiter_if;
  logic [0:3] req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:1] out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic alu_valid_out;
  logic [0:3] alu_cmd_out;
  logic [0:31] alu_op1_out, alu_op2_out;
  logic alu_done_in;
  logic [0:1] alu_resp_in;
  logic [0:31] alu_data_in;
  modport slave (
    input req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output alu_valid_out, alu_cmd_out, alu_op1_out, alu_op2_out,
    input alu_done_in, alu_resp_in, alu_data_in
  );
  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input out_resp1, out_resp2, out_resp3, out_resp4,
    input out_data1, out_data2, out_data3, out_data4,
    input alu_valid_out, alu_cmd_out, alu_op1_out, alu_op2_out,
    output alu_done_in, alu_resp_in, alu_data_in
  );
endinterface

// File: rtl/calc1_req_arbiter.sv
// calc1_req_arbiter: round-robin scheduler of four two-cycle requester ports onto one ALU; ports c_clk, reset (sync, active-high), bus (requesters in / responses out / ALU issue and result)
module calc1_req_arbiter #(
  parameter int ALU_TIMEOUT = 16
) (
  input logic c_clk,
  input logic reset,
  calc1_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {EMPTY, OP2, PENDING} slot_t;
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  state_t state_q, state_d;
  slot_t slot_q [4], slot_d [4];
  logic [0:3] cmd_q [4], cmd_d [4], cmd_in [4];
  logic [0:31] op1_q [4], op1_d [4], op2_q [4], op2_d [4], data_in [4];
  logic [1:0] grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [TW-1:0] timer_q, timer_d;
  logic [0:1] resp_q, resp_d;
  logic [0:31] res_q, res_d;
  logic [3:0] pend;
  logic issue, resp;

  function automatic logic cmd_ok(input logic [0:3] c);
    return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
  endfunction

  always_comb begin
    cmd_in[0] = bus.req1_cmd_in;
    cmd_in[1] = bus.req2_cmd_in;
    cmd_in[2] = bus.req3_cmd_in;
    cmd_in[3] = bus.req4_cmd_in;
    data_in[0] = bus.req1_data_in;
    data_in[1] = bus.req2_data_in;
    data_in[2] = bus.req3_data_in;
    data_in[3] = bus.req4_data_in;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
      cmd_d[i] = cmd_q[i];
      op1_d[i] = op1_q[i];
      op2_d[i] = op2_q[i];
      pend[i] = slot_q[i] == PENDING;
      if (slot_q[i] == EMPTY && cmd_in[i] != '0) begin
        slot_d[i] = OP2;
        cmd_d[i] = cmd_in[i];
        op1_d[i] = data_in[i];
      end else if (slot_q[i] == OP2) begin
        slot_d[i] = PENDING;
        op2_d[i] = data_in[i];
      end else if (slot_q[i] == PENDING && state_q == RESP && grant_q == 2'(i))
        slot_d[i] = EMPTY;
    end
  end

  // scan offsets high-to-low so the pending port closest to the pointer wins
  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (pend[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    timer_d = timer_q;
    resp_d = resp_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (|pend) begin
        grant_d = pick;
        state_d = cmd_ok(cmd_q[pick]) ? ISSUE : RESP;
        resp_d = 2'b10;
        res_d = '0;
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (bus.alu_done_in) begin
        state_d = RESP;
        resp_d = bus.alu_resp_in;
        res_d = bus.alu_data_in;
      end else if (timer_q == TW'(ALU_TIMEOUT - 1)) begin
        state_d = RESP;
        resp_d = 2'b11;
        res_d = '0;
      end else
        timer_d = timer_q + 1'b1;
      RESP: begin
        state_d = IDLE;
        ptr_d = grant_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      timer_q <= '0;
      resp_q <= '0;
      res_q <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= EMPTY;
        cmd_q[i] <= '0;
        op1_q[i] <= '0;
        op2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      timer_q <= timer_d;
      resp_q <= resp_d;
      res_q <= res_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
        cmd_q[i] <= cmd_d[i];
        op1_q[i] <= op1_d[i];
        op2_q[i] <= op2_d[i];
      end
    end
  end

  // the granted slot stays PENDING until RESP, so its registers feed the ALU directly
  assign issue = state_q == ISSUE;
  assign resp = state_q == RESP;
  assign bus.alu_valid_out = issue;
  assign bus.alu_cmd_out = issue ? cmd_q[grant_q] : '0;
  assign bus.alu_op1_out = issue ? op1_q[grant_q] : '0;
  assign bus.alu_op2_out = issue ? op2_q[grant_q] : '0;
  assign bus.out_resp1 = resp && grant_q == 2'd0 ? resp_q : '0;
  assign bus.out_resp2 = resp && grant_q == 2'd1 ? resp_q : '0;
  assign bus.out_resp3 = resp && grant_q == 2'd2 ? resp_q : '0;
  assign bus.out_resp4 = resp && grant_q == 2'd3 ? resp_q : '0;
  assign bus.out_data1 = resp && grant_q == 2'd0 ? res_q : '0;
  assign bus.out_data2 = resp && grant_q == 2'd1 ? res_q : '0;
  assign bus.out_data3 = resp && grant_q == 2'd2 ? res_q : '0;
  assign bus.out_data4 = resp && grant_q == 2'd3 ? res_q : '0;
endmodule

// File: tb/tb_calc1_req_arbiter.sv
// tb_calc1_req_arbiter: scoreboard bench for calc1_req_arbiter with a behavioural one-cycle ALU
module tb_calc1_req_arbiter;
  typedef struct {int port; logic [1:0] resp; logic [31:0] data; int cyc;} rsp_t;
  typedef struct {logic [3:0] cmd; logic [31:0] a; logic [31:0] b;} iss_t;
  logic c_clk = 0;
  logic reset = 1;
  always #5 c_clk = ~c_clk;
  calc1_req_arbiter_if bif();
  calc1_req_arbiter #(.ALU_TIMEOUT(16)) dut (.c_clk(c_clk), .reset(reset), .bus(bif));
  rsp_t sb[$];
  iss_t iq[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [3:0] tcmd [4], st_cmd [4];
  logic [31:0] tdat [4], st_a [4], st_b [4];
  logic silent = 0, late_done = 0, model_done = 0, pend_done = 0;
  logic [31:0] model_res = 0, pend_res = 0;
  logic [1:0] oresp [4];
  logic [31:0] odata [4];

  assign bif.req1_cmd_in = tcmd[0];
  assign bif.req2_cmd_in = tcmd[1];
  assign bif.req3_cmd_in = tcmd[2];
  assign bif.req4_cmd_in = tcmd[3];
  assign bif.req1_data_in = tdat[0];
  assign bif.req2_data_in = tdat[1];
  assign bif.req3_data_in = tdat[2];
  assign bif.req4_data_in = tdat[3];
  assign bif.alu_done_in = model_done | late_done;
  assign bif.alu_resp_in = model_done ? 2'b01 : late_done ? 2'b10 : 2'b00;
  assign bif.alu_data_in = model_done ? model_res : late_done ? 32'hdeadbeef : 32'h0;
  always_comb begin
    oresp[0] = bif.out_resp1;
    oresp[1] = bif.out_resp2;
    oresp[2] = bif.out_resp3;
    oresp[3] = bif.out_resp4;
    odata[0] = bif.out_data1;
    odata[1] = bif.out_data2;
    odata[2] = bif.out_data3;
    odata[3] = bif.out_data4;
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ok(input logic [3:0] c);
    return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
  endfunction

  function automatic logic [255:0] all_out();
    return {oresp[0], oresp[1], oresp[2], oresp[3], odata[0], odata[1], odata[2], odata[3],
            bif.alu_valid_out, bif.alu_cmd_out, bif.alu_op1_out, bif.alu_op2_out};
  endfunction

  always @(posedge c_clk) cyc <= cyc + 1;

  always @(negedge c_clk) begin
    model_done = pend_done;
    model_res = pend_res;
    pend_done = bif.alu_valid_out && !silent && !reset;
    pend_res = alu_f(bif.alu_cmd_out, bif.alu_op1_out, bif.alu_op2_out);
  end

  always @(negedge c_clk) if (!reset) begin
    if (bif.alu_valid_out) begin
      if (iq.size() == 0) check("issue_unexpected", 1, 0);
      else begin
        iss_t e;
        e = iq.pop_front();
        check("issue_cmd", bif.alu_cmd_out, e.cmd);
        check("issue_ops", {bif.alu_op1_out, bif.alu_op2_out}, {e.a, e.b});
      end
    end else if ({bif.alu_cmd_out, bif.alu_op1_out, bif.alu_op2_out} != 0)
      check("alu_idle_zero", {bif.alu_cmd_out, bif.alu_op1_out, bif.alu_op2_out}, 0);
    for (int p = 0; p < 4; p++)
      if (oresp[p] != 0) begin
        if (sb.size() == 0) check("resp_unexpected", {p[3:0], oresp[p], odata[p]}, 0);
        else begin
          rsp_t e;
          e = sb.pop_front();
          check("resp_port", p, e.port);
          check("resp_code", oresp[p], e.resp);
          check("resp_data", odata[p], e.data);
          if (e.cyc >= 0) check("resp_cycle", cyc, e.cyc);
        end
      end
  end

  task automatic stage(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    st_cmd[p] = c;
    st_a[p] = a;
    st_b[p] = b;
  endtask

  task automatic fire(input logic [3:0] mask, input int lat);
    rsp_t r;
    iss_t s;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        tcmd[p] = st_cmd[p];
        tdat[p] = st_a[p];
        r.port = p;
        r.resp = !ok(st_cmd[p]) ? 2'b10 : silent ? 2'b11 : 2'b01;
        r.data = (!ok(st_cmd[p]) || silent) ? 32'h0 : alu_f(st_cmd[p], st_a[p], st_b[p]);
        r.cyc = lat < 0 ? -1 : cyc + lat;
        sb.push_back(r);
        if (ok(st_cmd[p])) begin
          s.cmd = st_cmd[p];
          s.a = st_a[p];
          s.b = st_b[p];
          iq.push_back(s);
        end
      end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      tcmd[p] = 4'h0;
      if (mask[p]) tdat[p] = st_b[p];
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) tdat[p] = 32'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || iq.size() != 0); i++) @(negedge c_clk);
    check("drain", sb.size() + iq.size(), 0);
    repeat (3) @(negedge c_clk);
  endtask

  task automatic pulse_late_done();
    @(negedge c_clk);
    late_done = 1;
    @(negedge c_clk);
    late_done = 0;
    repeat (4) @(negedge c_clk);
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      tcmd[p] = 4'h0;
      tdat[p] = 32'h0;
    end
    repeat (3) @(negedge c_clk);
    check("reset_outputs", all_out(), 0);
    reset = 0;
    stage(0, 4'd1, 32'h1, 32'h2);
    fire(4'b0001, 5);
    drain();
    stage(1, 4'h3, 32'h1234, 32'h5678);
    fire(4'b0010, 3);
    drain();
    for (int k = 0; k < 32; k++) begin
      stage(3, 4'd1, 32'h1 << k, 32'h0);
      fire(4'b1000, 5);
      drain();
    end
    stage(0, 4'd1, 32'h10, 32'h5);
    stage(1, 4'd2, 32'h20, 32'h7);
    stage(2, 4'd5, 32'h30, 32'h4);
    stage(3, 4'd6, 32'hf000_0040, 32'h3);
    fire(4'b1111, -1);
    drain();
    stage(0, 4'd2, 32'h111, 32'h11);
    stage(2, 4'd1, 32'h333, 32'h33);
    fire(4'b0101, -1);
    drain();
    silent = 1;
    stage(0, 4'd1, 32'haa, 32'hbb);
    fire(4'b0001, 20);
    drain();
    silent = 0;
    pulse_late_done();
    stage(2, 4'd2, 32'h99, 32'h9);
    fire(4'b0100, -1);
    drain();
    silent = 1;
    stage(2, 4'd1, 32'h55, 32'h66);
    fire(4'b0100, -1);
    repeat (4) @(negedge c_clk);
    reset = 1;
    @(negedge c_clk);
    check("reset_in_wait", all_out(), 0);
    reset = 0;
    sb.delete();
    check("issued_before_reset", iq.size(), 0);
    iq.delete();
    silent = 0;
    pulse_late_done();
    stage(0, 4'd1, 32'h7, 32'h8);
    stage(3, 4'd2, 32'h70, 32'h8);
    fire(4'b1001, -1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
